cv32e40s_rf_ecc_scrubber: RTL and testbench

Background reader and corrector for the ECC-protected register file. During idle windows it walks registers x1..x(NUM_REGS-1), reads each stored codeword through a granted read port, and decodes it. A single-bit error is corrected and the clean codeword is written back through a granted write port. A double-bit error is reported on `ecc_err_o` and is not written back. It sits beside the register file and its ECC encoder, and arbitrates for spare port cycles.

---
 rtl/cv32e40s_rf_ecc_scrubber.sv | 137 +++++++++++++
 tb/tb_cv32e40s_rf_ecc_scrubber.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_rf_ecc_scrubber.sv
// cv32e40s_rf_ecc_scrubber: background SEC-DED scrubber for the register file.
module cv32e40s_rf_ecc_scrubber #(
  parameter int NUM_REGS       = 32,
  parameter int SCRUB_INTERVAL = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scrub_en_i,
  output logic        rreq_o,
  input  logic        rgnt_i,
  output logic [4:0]  raddr_o,
  input  logic [38:0] rdata_i,
  output logic        wreq_o,
  input  logic        wgnt_i,
  output logic [4:0]  waddr_o,
  output logic [38:0] wdata_o,
  input  logic        core_we_i,
  input  logic [4:0]  core_waddr_i,
  output logic        corr_o,
  output logic        ecc_err_o,
  output logic [4:0]  err_addr_o
);
  typedef enum logic [2:0] {IDLE, WAIT, READ, CHECK, WRITE} state_e;
  state_e      state_q, state_d, done_st;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  addr_q, addr_d, err_addr_q, err_addr_d, nxt_addr;
  logic [38:0] word_q, word_d, wdata_q, wdata_d, flip;
  logic        corr_q, corr_d, err_q, err_d;
  logic [5:0]  syn;
  logic        pe, fix_ok, clean, race;
  // Hamming position of codeword bit b; the overall parity bit sits at position 0.
  function automatic logic [5:0] cw_pos(input int b);
    int n;
    n = 0;
    cw_pos = '0;
    if (b >= 32 && b < 38) cw_pos = 6'(1 << (b - 32));
    else if (b < 32)
      for (int p = 3; p < 39; p++)
        if ((p & (p - 1)) != 0) begin
          if (n == b) cw_pos = 6'(p);
          n++;
        end
  endfunction
  always_comb begin
    syn = word_q[37:32];
    for (int b = 0; b < 32; b++) syn = word_q[b] ? syn ^ cw_pos(b) : syn;
    pe = ^word_q;
    fix_ok = pe && syn <= 6'd38;
    clean = syn == 6'd0 && !pe;
    flip = '0;
    for (int b = 0; b < 39; b++) flip[b] = fix_ok && cw_pos(b) == syn;
  end
  assign race     = core_we_i && core_waddr_i == addr_q;
  assign nxt_addr = addr_q == 5'(NUM_REGS - 1) ? 5'd1 : addr_q + 5'd1;
  assign done_st  = scrub_en_i ? WAIT : IDLE;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    err_addr_d = err_addr_q;
    corr_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: state_d = scrub_en_i ? WAIT : IDLE;
      WAIT: begin
        if (!scrub_en_i) state_d = IDLE;
        else if (cnt_q == 16'(SCRUB_INTERVAL - 1)) begin
          cnt_d   = '0;
          state_d = READ;
        end else cnt_d = cnt_q + 16'd1;
      end
      READ: begin
        if (!scrub_en_i) state_d = IDLE;
        else if (rgnt_i) begin
          word_d  = rdata_i;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (clean) begin
          addr_d  = nxt_addr;
          state_d = done_st;
        end else if (!fix_ok) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          addr_d     = nxt_addr;
          state_d    = done_st;
        end else begin
          corr_d     = 1'b1;
          err_addr_d = addr_q;
          wdata_d    = word_q ^ flip;
          addr_d     = race ? nxt_addr : addr_q;
          state_d    = race ? done_st : WRITE;
        end
      end
      WRITE: begin
        // A core write to the same register is newer; the correction is discarded.
        if (wgnt_i || race) begin
          addr_d  = nxt_addr;
          state_d = done_st;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= 5'd1;
      word_q     <= '0;
      wdata_q    <= '0;
      err_addr_q <= '0;
      corr_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      err_addr_q <= err_addr_d;
      corr_q     <= corr_d;
      err_q      <= err_d;
    end
  end
  assign rreq_o     = state_q == READ;
  assign raddr_o    = rreq_o ? addr_q : 5'd0;
  assign wreq_o     = state_q == WRITE;
  assign waddr_o    = wreq_o ? addr_q : 5'd0;
  assign wdata_o    = wdata_q;
  assign corr_o     = corr_q;
  assign ecc_err_o  = err_q;
  assign err_addr_o = err_addr_q;
endmodule

// File: tb/tb_cv32e40s_rf_ecc_scrubber.sv
// tb_cv32e40s_rf_ecc_scrubber: scoreboard bench with a register-file model behind the scrubber.
module tb_cv32e40s_rf_ecc_scrubber;
  localparam int SI = 4;
  logic        clk = 1'b0, rst_n = 1'b0, scrub_en_i = 1'b0, rgnt_i = 1'b1, wgnt_i = 1'b1, core_we_i = 1'b0;
  logic [4:0]  core_waddr_i = 5'd0;
  logic        rreq_o, wreq_o, corr_o, ecc_err_o;
  logic [4:0]  raddr_o, waddr_o, err_addr_o;
  logic [38:0] rdata_i, wdata_o;
  logic [38:0] mem [32];
  logic [38:0] golden [32];
  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [38:0] data;
  } exp_t;
  exp_t eq[$];
  exp_t wq[$];
  int n_tests = 0, n_fail = 0, nreads = 0, cyc = 0, last_rd = -1, corr_cnt = 0, err_cnt = 0, n0;
  logic [4:0] exp_addr = 5'd1, last_raddr = 5'd0;
  bit gap_chk = 1'b0;

  cv32e40s_rf_ecc_scrubber #(.NUM_REGS(32), .SCRUB_INTERVAL(SI)) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en_i(scrub_en_i),
    .rreq_o(rreq_o), .rgnt_i(rgnt_i), .raddr_o(raddr_o), .rdata_i(rdata_i),
    .wreq_o(wreq_o), .wgnt_i(wgnt_i), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .core_we_i(core_we_i), .core_waddr_i(core_waddr_i),
    .corr_o(corr_o), .ecc_err_o(ecc_err_o), .err_addr_o(err_addr_o)
  );

  assign rdata_i = mem[raddr_o];
  always #5 clk = ~clk;

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [5:0] c;
    int n;
    c = '0;
    n = 0;
    for (int p = 3; p < 39; p++)
      if ((p & (p - 1)) != 0) begin
        for (int k = 0; k < 6; k++) if (p[k]) c[k] ^= d[n];
        n++;
      end
    return {^{c, d}, c, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_reads(input int n, input string tag);
    int t = 0;
    while (nreads < n && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(nreads >= n), 1);
  endtask

  task automatic wait_wreq(input string tag);
    int t = 0;
    while (!wreq_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(wreq_o), 1);
  endtask

  task automatic chk_outs_zero(input string pfx);
    chk({pfx, "_rreq"}, 64'(rreq_o), 0);
    chk({pfx, "_wreq"}, 64'(wreq_o), 0);
    chk({pfx, "_corr"}, 64'(corr_o), 0);
    chk({pfx, "_err"}, 64'(ecc_err_o), 0);
    chk({pfx, "_raddr"}, 64'(raddr_o), 0);
    chk({pfx, "_waddr"}, 64'(waddr_o), 0);
    chk({pfx, "_wdata"}, 64'(wdata_o), 0);
    chk({pfx, "_err_addr"}, 64'(err_addr_o), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int pc;
    cyc++;
    if (!rst_n) begin
      exp_addr = 5'd1;
      eq.delete();
      wq.delete();
      last_rd = -1;
    end else begin
      if (rreq_o && rgnt_i) begin
        chk("raddr", 64'(raddr_o), 64'(exp_addr));
        last_raddr = raddr_o;
        nreads++;
        if (gap_chk && last_rd >= 0) chk("read_gap", 64'(cyc - last_rd), SI + 2);
        last_rd = gap_chk ? cyc : -1;
        pc = $countones(mem[exp_addr] ^ golden[exp_addr]);
        if (pc != 0) begin
          e.kind = pc == 1 ? 2'b10 : 2'b01;
          e.addr = exp_addr;
          e.data = golden[exp_addr];
          eq.push_back(e);
        end
        exp_addr = exp_addr == 5'd31 ? 5'd1 : exp_addr + 5'd1;
      end
      if (corr_o || ecc_err_o) begin
        corr_cnt += int'(corr_o);
        err_cnt += int'(ecc_err_o);
        if (eq.size() == 0) chk("evt_unexpected", 64'({corr_o, ecc_err_o}), 0);
        else begin
          e = eq.pop_front();
          chk("evt_kind", 64'({corr_o, ecc_err_o}), 64'(e.kind));
          chk("err_addr", 64'(err_addr_o), 64'(e.addr));
          chk(corr_o ? "wreq_rise" : "no_wreq", 64'(wreq_o), 64'(corr_o));
          if (corr_o) wq.push_back(e);
        end
      end
      if (wreq_o && wgnt_i) begin
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = wq.pop_front();
          chk("waddr", 64'(waddr_o), 64'(e.addr));
          chk("wdata", 64'(wdata_o), 64'(e.data));
          mem[waddr_o] = wdata_o;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      golden[i] = enc($urandom);
      mem[i] = golden[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    gap_chk = 1'b1;
    scrub_en_i = 1'b1;
    wait_reads(32, "clean_walk");
    gap_chk = 1'b0;
    chk("clean_corr", 64'(corr_cnt), 0);
    chk("clean_err", 64'(err_cnt), 0);
    chk("wrap_addr", 64'(last_raddr), 1);
    golden[5] = enc(32'h0);
    mem[5] = 39'h1;
    golden[7] = enc(32'h0);
    mem[7] = 39'h3;
    wait_reads(38, "x7_read");
    repeat (4) @(negedge clk);
    chk("x5_fixed", 64'(mem[5]), 0);
    chk("corr_cnt_x5", 64'(corr_cnt), 1);
    chk("err_cnt_x7", 64'(err_cnt), 1);
    chk("err_addr_x7", 64'(err_addr_o), 7);
    mem[7] = golden[7];
    wgnt_i = 1'b0;
    golden[9] = enc($urandom);
    mem[9] = golden[9] ^ (39'd1 << 20);
    wait_wreq("x9_wreq");
    repeat (10) begin
      @(negedge clk);
      chk("stall_wreq", 64'(wreq_o), 1);
      chk("stall_waddr", 64'(waddr_o), 9);
      chk("stall_wdata", 64'(wdata_o), 64'(golden[9]));
    end
    @(posedge clk); #1;
    core_we_i = 1'b1;
    core_waddr_i = 5'd9;
    mem[9] = golden[9];
    @(posedge clk); #1;
    core_we_i = 1'b0;
    wq.delete();
    @(negedge clk);
    chk("race_drop", 64'(wreq_o), 0);
    wgnt_i = 1'b1;
    n0 = nreads;
    wait_reads(n0 + 1, "after_race_read");
    chk("after_race_addr", 64'(last_raddr), 10);
    @(posedge clk); #1;
    rgnt_i = 1'b0;
    begin
      int t = 0;
      while (!rreq_o && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    chk("stall_rreq", 64'(rreq_o), 1);
    chk("stall_raddr", 64'(raddr_o), 11);
    @(posedge clk); #1;
    scrub_en_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("drop_rreq", 64'(rreq_o), 0);
    repeat (3) @(negedge clk);
    chk("idle_rreq", 64'(rreq_o), 0);
    golden[12] = enc($urandom);
    mem[12] = golden[12] ^ (39'd1 << 33);
    @(posedge clk); #1;
    rgnt_i = 1'b1;
    wgnt_i = 1'b0;
    scrub_en_i = 1'b1;
    n0 = nreads;
    wait_reads(n0 + 1, "reenable_read");
    chk("same_addr", 64'(last_raddr), 11);
    wait_wreq("x12_wreq");
    chk("x12_waddr", 64'(waddr_o), 12);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_outs_zero("wr_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wgnt_i = 1'b1;
    mem[12] = golden[12];
    n0 = nreads;
    wait_reads(n0 + 1, "post_reset_read");
    chk("post_reset_addr", 64'(last_raddr), 1);
    repeat (3) @(negedge clk);
    chk("eq_empty", 64'(eq.size()), 0);
    chk("wq_empty", 64'(wq.size()), 0);
    chk("corr_total", 64'(corr_cnt), 3);
    chk("err_total", 64'(err_cnt), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
